// File: rtl/adc_sar_pkg.sv
// Shared types and sizing helpers for the SAR conversion controller.
// ADC_SAR_AVG_EN (optional) enables 4-pass averaging in adc_sar_ctrl.
package adc_sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SAMPLE,
        TRIAL_SET,
        TRIAL_CMP,
        DONE
    } adc_sar_state_e;

    localparam int AVG_PASSES = 4;

    // Sizing helpers, evaluated against the instantiating module's parameters.
    function automatic int sample_cnt_w(input int sample_cycles);
        return $clog2(sample_cycles + 1);
    endfunction

    function automatic int bit_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/adc_sar_if.sv
// Host-side start/done handshake of the SAR controller.
// The master modport is the register/JTAG instrument side; slave is the controller.
interface adc_sar_if #(
    parameter int N = 12
);
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] result;

    modport master (output start, input busy, done, err, result);
    modport slave  (input start, output busy, done, err, result);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous status lines from analog macros.
// clr_i flushes both stages so a fresh level must propagate through the pair.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking here so both stages sample the pre-edge values and form a real two-stage pipe.
        if (rst || clr_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/adc_sar_ctrl.sv
// SAR conversion controller: drives sample switch, comparator clock and DAC code of the analog macro.
// Define ADC_SAR_AVG_EN to average 4 back-to-back conversions per start.
module adc_sar_ctrl
    import adc_sar_pkg::*;
#(
    parameter int N             = 12,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    adc_sar_if.slave     host,
    output logic         ms_clk_o,
    output logic         ms_sample_o,
    output logic [N-1:0] ms_dac_o,
    input  logic         ms_rdy_i,
    input  logic         ms_cmp_i
);
    localparam int CNT_W = sample_cnt_w(SAMPLE_CYCLES);
    localparam int IDX_W = bit_idx_w(N);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(N - 1);

    adc_sar_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     code_q, code_d, code_cmp;
    logic [N-1:0]     result_q, result_d;
    logic [N-1:0]     dac_q, dac_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ms_clk_q, ms_clk_d;
    logic             ms_sample_q, ms_sample_d;
    logic             rdy_sync;
`ifdef ADC_SAR_AVG_EN
    logic [1:0]       pass_q, pass_d;
    logic [N+1:0]     sum_q, sum_d, sum_next;
`endif

    // Flushed in IDLE so every conversion waits out the full synchronizer delay on ms_rdy.
    sync_2ff #(.W(1)) u_rdy_sync (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == IDLE),
        .d_i   (ms_rdy_i),
        .q_o   (rdy_sync)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        code_d   = code_q;
        result_d = result_q;
        err_d    = 1'b0;
        code_cmp = code_q;
        code_cmp[idx_q] = ms_cmp_i;
`ifdef ADC_SAR_AVG_EN
        pass_d   = pass_q;
        sum_d    = sum_q;
        sum_next = sum_q + {2'b00, code_cmp};
`endif

        unique case (state_q)
            IDLE: begin
                if (host.start) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (rdy_sync) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
`ifdef ADC_SAR_AVG_EN
                    pass_d  = '0;
                    sum_d   = '0;
`endif
                end
            end
            SAMPLE: begin
                if (!rdy_sync) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == SAMPLE_LAST) begin
                    state_d = TRIAL_SET;
                    idx_d   = IDX_MSB;
                    code_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRIAL_SET: begin
                if (!rdy_sync) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = TRIAL_CMP;
                end
            end
            TRIAL_CMP: begin
                if (!rdy_sync) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    code_d = code_cmp;
                    if (idx_q == '0) begin
`ifdef ADC_SAR_AVG_EN
                        if (pass_q == 2'(AVG_PASSES - 1)) begin
                            state_d  = DONE;
                            result_d = sum_next[N+1:2];
                        end else begin
                            state_d = SAMPLE;
                            cnt_d   = '0;
                            pass_d  = pass_q + 1'b1;
                            sum_d   = sum_next;
                        end
`else
                        state_d  = DONE;
                        result_d = code_cmp;
`endif
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = TRIAL_SET;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, keeping ms_clk glitch-free.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        ms_sample_d = (state_d == SAMPLE);
        ms_clk_d    = (state_d == TRIAL_CMP);
        dac_d       = (state_d == TRIAL_SET || state_d == TRIAL_CMP)
                      ? (code_d | (N'(1) << idx_d)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            code_q      <= '0;
            result_q    <= '0;
            dac_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ms_clk_q    <= 1'b0;
            ms_sample_q <= 1'b0;
`ifdef ADC_SAR_AVG_EN
            pass_q      <= '0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            result_q    <= result_d;
            dac_q       <= dac_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ms_clk_q    <= ms_clk_d;
            ms_sample_q <= ms_sample_d;
`ifdef ADC_SAR_AVG_EN
            pass_q      <= pass_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.err    = err_q;
    assign host.result = result_q;
    assign ms_clk_o    = ms_clk_q;
    assign ms_sample_o = ms_sample_q;
    assign ms_dac_o    = dac_q;
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Self-checking bench for adc_sar_ctrl with an ideal comparator (ms_cmp = target >= ms_dac).
// Averaging scenario is built when ADC_SAR_AVG_EN is defined.
module tb_adc_sar_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        ms_clk, ms_sample, ms_rdy, ms_cmp;
    logic [11:0] ms_dac;
    logic [11:0] target;
    logic [11:0] dac_log [16];
    int          checks   = 0;
    int          failures = 0;

    adc_sar_if #(.N(12)) hif ();

    adc_sar_ctrl #(.N(12), .SAMPLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .ms_clk_o    (ms_clk),
        .ms_sample_o (ms_sample),
        .ms_dac_o    (ms_dac),
        .ms_rdy_i    (ms_rdy),
        .ms_cmp_i    (ms_cmp)
    );

    always #5 clk = ~clk;
    assign ms_cmp = (target >= ms_dac);

    typedef struct {
        logic [11:0] target;
        logic [11:0] exp_result;
        int          exp_lat;
        int          exp_samp;
        int          exp_clk;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Start is driven between edges so exactly one rising edge samples it.
    task automatic pulse_start();
        @(negedge clk);
        hif.start = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
    endtask

    // Returns at the negedge of the cycle where done was seen (cycle 1 = first after the start edge).
    task automatic run_conv(input logic [11:0] tgt, input int budget, input bit extra_start,
                            input bit step_target, output int lat, output int n_samp,
                            output int n_clk, output int n_busy_low, output int n_err);
        logic prev_clk, prev_samp;
        int   rises;
        target = tgt;
        lat = -1; n_samp = 0; n_clk = 0; n_busy_low = 0; n_err = 0;
        prev_clk = 1'b0; prev_samp = 1'b0; rises = 0;
        for (int i = 0; i < 16; i++) dac_log[i] = '0;
        pulse_start();
        for (int k = 1; k <= budget; k++) begin
            hif.start = (extra_start && k == 10);
            if (ms_sample && !prev_samp) begin
                if (step_target) target = tgt + 12'(rises);
                rises++;
            end
            if (ms_sample) n_samp++;
            if (ms_clk && !prev_clk) begin
                if (n_clk < 16) dac_log[n_clk] = ms_dac;
                n_clk++;
            end
            if (!hif.busy) n_busy_low++;
            if (hif.err) n_err++;
            if (hif.done) begin
                lat = k;
                break;
            end
            prev_clk  = ms_clk;
            prev_samp = ms_sample;
            @(negedge clk);
        end
        hif.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [11:0] exp_result);
        check({tag, "_busy"},   32'(hif.busy),   32'd0);
        check({tag, "_done"},   32'(hif.done),   32'd0);
        check({tag, "_err"},    32'(hif.err),    32'd0);
        check({tag, "_result"}, 32'(hif.result), 32'(exp_result));
        check({tag, "_ms_clk"}, 32'(ms_clk),     32'd0);
        check({tag, "_ms_smp"}, 32'(ms_sample),  32'd0);
        check({tag, "_ms_dac"}, 32'(ms_dac),     32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [6];
        int          lat, n_samp, n_clk, n_busy_low, n_err, dac_bad, at;
        logic [11:0] mcode, trial;
        bit          seen_done;

        vecs[0] = '{12'h800, 12'h800, 32, 4, 12};
        vecs[1] = '{12'hFFF, 12'hFFF, 32, 4, 12};
        vecs[2] = '{12'h000, 12'h000, 32, 4, 12};
        vecs[3] = '{12'h001, 12'h001, 32, 4, 12};
        vecs[4] = '{12'hAAA, 12'hAAA, 32, 4, 12};
        vecs[5] = '{12'h7FF, 12'h7FF, 32, 4, 12};

        rst = 1'b1; hif.start = 1'b0; ms_rdy = 1'b1; target = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 12'h000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifndef ADC_SAR_AVG_EN
        foreach (vecs[v]) begin
            run_conv(vecs[v].target, 60, 1'b0, 1'b0, lat, n_samp, n_clk, n_busy_low, n_err);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_result", v), 32'(hif.result), 32'(vecs[v].exp_result));
            check($sformatf("v%0d_sample_cycles", v), 32'(n_samp), 32'(vecs[v].exp_samp));
            check($sformatf("v%0d_ms_clk_pulses", v), 32'(n_clk), 32'(vecs[v].exp_clk));
            check($sformatf("v%0d_busy_gaps", v), 32'(n_busy_low), 32'd0);
            check($sformatf("v%0d_err", v), 32'(n_err), 32'd0);
            mcode = '0; dac_bad = 0;
            for (int b = 11; b >= 0; b--) begin
                trial = mcode | (12'd1 << b);
                if (dac_log[11 - b] !== trial) dac_bad++;
                if (vecs[v].target >= trial) mcode = trial;
            end
            check($sformatf("v%0d_dac_sequence", v), 32'(dac_bad), 32'd0);
            if (v == 0) begin
                check("v0_dac0", 32'(dac_log[0]), 32'h800);
                check("v0_dac1", 32'(dac_log[1]), 32'hC00);
                check("v0_dac2", 32'(dac_log[2]), 32'hA00);
            end
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 32'(hif.done), 32'd0);
            check($sformatf("v%0d_busy_after", v), 32'(hif.busy), 32'd0);
        end

        // ms_rdy low at start: sampling must wait for the level to clear both sync stages.
        ms_rdy = 1'b0; target = 12'h5A3;
        pulse_start();
        n_samp = 0;
        for (int k = 0; k < 10; k++) begin
            if (ms_sample) n_samp++;
            @(negedge clk);
        end
        check("rdylate_no_sample", 32'(n_samp), 32'd0);
        check("rdylate_busy", 32'(hif.busy), 32'd1);
        ms_rdy = 1'b1;
        at = -1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (ms_sample) begin
                at = j;
                break;
            end
        end
        check("rdylate_sample_delay", 32'(at), 32'd3);
        seen_done = 1'b0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            @(negedge clk);
            if (hif.done) seen_done = 1'b1;
        end
        check("rdylate_done_seen", 32'(seen_done), 32'd1);
        check("rdylate_result", 32'(hif.result), 32'h5A3);
        @(negedge clk);

        // Abort: drop ms_rdy as the bit-6 trial code appears.
        target = 12'h123;
        pulse_start();
        at = -1;
        for (int k = 0; k < 40; k++) begin
            if (ms_dac == 12'h5C0 || ms_dac == 12'h140) begin
                at = k;
                break;
            end
            @(negedge clk);
        end
        // target 0x123 makes bit-6 trial code 0x140; abort must still leave old result
        check("abort_bit6_reached", 32'(at >= 0), 32'd1);
        ms_rdy = 1'b0;
        at = -1; seen_done = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (hif.done) seen_done = 1'b1;
            if (hif.err) begin
                at = j;
                break;
            end
        end
        check("abort_err_delay", 32'(at), 32'd3);
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_ms_clk", 32'(ms_clk), 32'd0);
        check("abort_ms_sample", 32'(ms_sample), 32'd0);
        check("abort_ms_dac", 32'(ms_dac), 32'd0);
        check("abort_busy", 32'(hif.busy), 32'd0);
        check("abort_result_kept", 32'(hif.result), 32'h5A3);
        @(negedge clk);
        check("abort_err_pulse", 32'(hif.err), 32'd0);
        ms_rdy = 1'b1;
        repeat (3) @(negedge clk);

        // Second start while busy must be ignored, with no queued conversion afterwards.
        run_conv(12'h3C5, 60, 1'b1, 1'b0, lat, n_samp, n_clk, n_busy_low, n_err);
        check("busystart_latency", 32'(lat), 32'd32);
        check("busystart_result", 32'(hif.result), 32'h3C5);
        n_busy_low = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hif.busy) n_busy_low++;
        end
        check("busystart_not_queued", 32'(n_busy_low), 32'd0);

        // Synchronous reset during a TRIAL_CMP cycle.
        target = 12'h9B7;
        pulse_start();
        at = 0;
        for (int k = 0; k < 40 && at < 3; k++) begin
            if (ms_clk) at++;
            if (at < 3) @(negedge clk);
        end
        check("rst_reached_cmp", 32'(ms_clk), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_mid", 12'h000);
        n_err = 0; seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hif.err) n_err++;
            if (hif.done || hif.busy) seen_done = 1'b1;
        end
        check("rst_no_err", 32'(n_err), 32'd0);
        check("rst_no_activity", 32'(seen_done), 32'd0);
        run_conv(12'h9B7, 60, 1'b0, 1'b0, lat, n_samp, n_clk, n_busy_low, n_err);
        check("postrst_latency", 32'(lat), 32'd32);
        check("postrst_result", 32'(hif.result), 32'h9B7);
`else
        // Four passes at 0x100..0x103 average to 0x101.
        run_conv(12'h100, 200, 1'b0, 1'b1, lat, n_samp, n_clk, n_busy_low, n_err);
        check("avg_latency", 32'(lat), 32'd116);
        check("avg_result", 32'(hif.result), 32'h101);
        check("avg_sample_cycles", 32'(n_samp), 32'd16);
        check("avg_ms_clk_pulses", 32'(n_clk), 32'd48);
        check("avg_busy_gaps", 32'(n_busy_low), 32'd0);
        check("avg_err", 32'(n_err), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (hif.done || hif.busy) seen_done = 1'b1;
        end
        check("avg_single_done", 32'(seen_done), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_sar_ctrl.md
Name: adc_sar_ctrl

Overview:
Digital SAR conversion controller for the mixed-signal SAR ADC instrument; it sits on the digital side of the ms_adc_* interface.
- Drives the analog macro's sample switch, comparator clock and capacitive-DAC code.
- Consumes the macro's ready and comparator outputs.
- Runs a binary search MSB to LSB and presents the N-bit result to the chip's register/JTAG instrument logic with a start/done handshake.

Parameters:
N, 12, converter resolution in bits (width of ms_dac and result); legal range 4..16
SAMPLE_CYCLES, 4, clk cycles ms_sample is held high for track phase; legal range 1..255

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  conversion request; sampled only in IDLE
busy  output  1  high from first cycle after accepted start until the cycle done is high (inclusive)
done  output  1  one-cycle pulse, result valid
err  output  1  one-cycle pulse, conversion aborted because ms_rdy fell
result  output  N  last completed code; holds until next done
ms_clk  output  1  comparator clock to analog macro
ms_sample  output  1  sample/track switch enable
ms_dac  output  N  DAC trial code
ms_rdy  input  1  analog macro biased and ready (asynchronous source, 2-flop synchronized internally)
ms_cmp  input  1  comparator decision: 1 = input above DAC level

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, result=0, ms_clk=0, ms_sample=0, ms_dac=0, state=IDLE, sync flops=0.
- States: IDLE, WAIT_RDY, SAMPLE, TRIAL_SET, TRIAL_CMP, DONE.
- IDLE: outputs low, ms_dac=0. start=1 -> WAIT_RDY. start in any other state is ignored, with no queueing.
- WAIT_RDY: waits indefinitely for synchronized ms_rdy=1, then -> SAMPLE.
- SAMPLE: ms_sample=1 for exactly SAMPLE_CYCLES cycles, ms_dac=0. Then bit index i=N-1, code=0 -> TRIAL_SET.
- TRIAL_SET (1 cycle): ms_dac = code | (1<<i), ms_clk=0. -> TRIAL_CMP.
- TRIAL_CMP (1 cycle): ms_clk=1, ms_dac unchanged.
  - At the closing edge, ms_cmp is sampled directly (comparator output is settled and synchronous to ms_clk).
  - ms_cmp=1: code[i]=1; otherwise code[i]=0.
  - If i=0 -> DONE; else i=i-1 -> TRIAL_SET.
- DONE (1 cycle): result<=code, done=1, busy=1, ms_clk=0, ms_dac=0. -> IDLE.
- Latency with ms_rdy already high (counting the sync-flop stages): done high exactly SAMPLE_CYCLES+2N+4 cycles after the edge that samples start=1. For default parameters this is 32 cycles.
- ms_clk is a registered output, glitch-free, at half clk rate during conversion only.
- Abort: synchronized ms_rdy=0 in SAMPLE, TRIAL_SET or TRIAL_CMP:
  - err=1 for one cycle and all ms_* outputs go low;
  - result is unchanged, done is not asserted;
  - next state is IDLE.
- rst asserted mid-conversion: all outputs take reset values on the next edge, with no done and no err.
- Code extremes: all-ones comparator gives result = 2^N-1; all-zeros gives 0. No overflow is possible.

Optional Feature:
ADC_SAR_AVG_EN:
- Defined: each accepted start runs 4 back-to-back conversions. Each repeats SAMPLE followed by the N trials, with no WAIT_RDY between conversions.
- Codes are accumulated in an N+2-bit sum; result = sum>>2 (truncating); done pulses once after the 4th conversion.
- Latency = 4*(SAMPLE_CYCLES+2N)+4.
- An abort in any pass discards the sum and pulses err.
- Undefined: single conversion exactly as above, and no accumulator is synthesized.

Decomposition:
- Shared package adc_sar_pkg holds:
  - the state enum adc_sar_state_e;
  - localparam SAMPLE_CNT_W = $clog2(SAMPLE_CYCLES+1);
  - the bit-index width $clog2(N);
  - AVG_PASSES=4.
- One natural sub-module, sync_2ff: ms_rdy synchronizer, reused elsewhere for analog status lines.
- The FSM, counters and SAR register stay in adc_sar_ctrl.

Test Plan:
- Ideal comparator model (ms_cmp = target >= ms_dac), target=0x800, ms_rdy=1, start pulse -> done at cycle 32, result=0x800, ms_dac trial sequence 0x800,0xC00,0xA00,... observed.
- target=0xFFF and target=0x000 -> result=0xFFF and 0x000 respectively; ms_sample high exactly 4 cycles; ms_clk exactly 12 high pulses.
- ms_rdy=0 at start, raised 10 cycles later -> ms_sample does not rise until ms_rdy has passed the 2-flop sync; result=target (target=0x5A3 -> 0x5A3).
- ms_rdy dropped during trial of bit 6 -> err one cycle, no done, result keeps previous 0x5A3, ms_* all 0, busy=0.
- start pulsed again while busy, then rst asserted mid-TRIAL_CMP -> second start ignored; after rst all outputs 0 and the next start converts normally.
- ADC_SAR_AVG_EN defined, target alternating 0x100,0x101,0x102,0x103 per pass -> result=0x101, single done at cycle 4*28+4=116.
